// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage pipelined CPU.
// Contents:
//   DW, RW      - default datapath width and register-index width
//   ALU_*       - 4-bit ALU control encodings
//   fwd_sel_e   - operand forward-select encodings, produced by
//                 forwarding_unit and consumed by the operand muxes
package cpu_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_EQ  = 4'd8;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_MUL = 4'd15;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,  // use the register-file value
    FWD_WB  = 2'd1,  // forward MEM/WB write-back data
    FWD_MEM = 2'd2   // forward EX/MEM ALU result
  } fwd_sel_e;

endpackage

// File: rtl/forwarding_unit.sv
// Combinational RAW-hazard detector.
// Compares two source register indices against the EX/MEM and MEM/WB
// destinations and reports where each operand should come from.
// EX/MEM (younger) wins over MEM/WB; register $0 is never forwarded.
// Also used by the MEM stage for store-data hazards.
// Ports:
//   rs, rt                        - source register indices
//   exmem_reg_write, exmem_wreg   - EX/MEM write enable and destination
//   memwb_reg_write, memwb_wreg   - MEM/WB write enable and destination
//   fwd_a, fwd_b                  - forward selects for rs and rt
module forwarding_unit #(
  parameter int unsigned RW = cpu_pkg::RW
) (
  input  logic             [RW-1:0] rs,
  input  logic             [RW-1:0] rt,
  input  logic                      exmem_reg_write,
  input  logic             [RW-1:0] exmem_wreg,
  input  logic                      memwb_reg_write,
  input  logic             [RW-1:0] memwb_wreg,
  output cpu_pkg::fwd_sel_e         fwd_a,
  output cpu_pkg::fwd_sel_e         fwd_b
);
  import cpu_pkg::*;

  function automatic fwd_sel_e select_src(
    input logic [RW-1:0] src,
    input logic          ex_we,
    input logic [RW-1:0] ex_wreg,
    input logic          wb_we,
    input logic [RW-1:0] wb_wreg
  );
    if (ex_we && (ex_wreg != '0) && (ex_wreg == src)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_wreg != '0) && (wb_wreg == src)) begin
      return FWD_WB;
    end
    return FWD_REG;
  endfunction

  always_comb begin
    fwd_a = select_src(rs, exmem_reg_write, exmem_wreg,
                       memwb_reg_write, memwb_wreg);
    fwd_b = select_src(rt, exmem_reg_write, exmem_wreg,
                       memwb_reg_write, memwb_wreg);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand forwarding.
// Latches decoded operands and control each cycle; holds under stall,
// clears to a bubble under flush or when the decoded slot is invalid.
// Operands are resolved against EX/MEM and MEM/WB results combinationally.
// Edge priority: rst_i > flush_i > stall_i > load.
// Ports:
//   clk_i, rst_i                    - clock, synchronous active-high reset
//   stall_i, flush_i                - hold / bubble controls
//   valid_i, rs/rt_data_i, imm_i    - decoded instruction and operands
//   rs_i, rt_i, rd_i                - register indices
//   alu_ctrl_i, alu_src_i, reg_dst_i - ALU and destination selection
//   reg_write_i .. mem_to_reg_i     - downstream control
//   exmem_*, memwb_*                - later-stage results for forwarding
//   src1_o, src2_o, ctrl_o          - ALU operands and control
//   store_data_o                    - forwarded rt value for stores
//   wreg_o                          - selected destination register
//   valid_o .. mem_to_reg_o         - registered control
module id_ex_stage #(
  parameter int unsigned DW = cpu_pkg::DW,
  parameter int unsigned RW = cpu_pkg::RW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] imm_i,
  input  logic [RW-1:0] rs_i,
  input  logic [RW-1:0] rt_i,
  input  logic [RW-1:0] rd_i,
  input  logic [3:0]    alu_ctrl_i,
  input  logic          alu_src_i,
  input  logic          reg_dst_i,
  input  logic          reg_write_i,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic          mem_to_reg_i,
  input  logic          exmem_reg_write_i,
  input  logic [RW-1:0] exmem_wreg_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [RW-1:0] memwb_wreg_i,
  input  logic [DW-1:0] memwb_wdata_i,
  output logic [DW-1:0] src1_o,
  output logic [DW-1:0] src2_o,
  output logic [3:0]    ctrl_o,
  output logic [DW-1:0] store_data_o,
  output logic [RW-1:0] wreg_o,
  output logic          valid_o,
  output logic          reg_write_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          mem_to_reg_o
);
  import cpu_pkg::*;

  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic [RW-1:0] rd_q;
  logic [3:0]    alu_ctrl_q;
  logic          alu_src_q;
  logic          reg_dst_q;
  logic          valid_q;
  logic          reg_write_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic          mem_to_reg_q;

  // Reset, flush and an invalid decode slot all leave the same
  // all-zero bubble, so they share one clear path.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || (!stall_i && !valid_i)) begin
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!stall_i) begin
      rs_data_q    <= rs_data_i;
      rt_data_q    <= rt_data_i;
      imm_q        <= imm_i;
      rs_q         <= rs_i;
      rt_q         <= rt_i;
      rd_q         <= rd_i;
      alu_ctrl_q   <= alu_ctrl_i;
      alu_src_q    <= alu_src_i;
      reg_dst_q    <= reg_dst_i;
      valid_q      <= 1'b1;
      reg_write_q  <= reg_write_i;
      mem_read_q   <= mem_read_i;
      mem_write_q  <= mem_write_i;
      mem_to_reg_q <= mem_to_reg_i;
    end
  end

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  forwarding_unit #(
    .RW (RW)
  ) u_fwd (
    .rs              (rs_q),
    .rt              (rt_q),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_wreg      (exmem_wreg_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_wreg      (memwb_wreg_i),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  logic [DW-1:0] rt_fwd;

  always_comb begin
    case (fwd_a)
      FWD_MEM: src1_o = exmem_result_i;
      FWD_WB:  src1_o = memwb_wdata_i;
      default: src1_o = rs_data_q;
    endcase

    case (fwd_b)
      FWD_MEM: rt_fwd = exmem_result_i;
      FWD_WB:  rt_fwd = memwb_wdata_i;
      default: rt_fwd = rt_data_q;
    endcase

    // The immediate bypasses forwarding; stores still need the forwarded rt.
    src2_o       = alu_src_q ? imm_q : rt_fwd;
    store_data_o = rt_fwd;
    wreg_o       = reg_dst_q ? rd_q : rt_q;
  end

  assign ctrl_o       = alu_ctrl_q;
  assign valid_o      = valid_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_to_reg_o = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// stall/flush sequences, and randomized traffic against a behavioural model.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic [3:0]  alu_ctrl_i;
  logic        alu_src_i, reg_dst_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_wreg_i;
  logic [31:0] exmem_result_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_wreg_i;
  logic [31:0] memwb_wdata_i;
  logic [31:0] src1_o, src2_o, store_data_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  wreg_o;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .alu_ctrl_i(alu_ctrl_i), .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_wreg_i(exmem_wreg_i),
    .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_wreg_i(memwb_wreg_i), .memwb_wdata_i(memwb_wdata_i),
    .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o),
    .store_data_o(store_data_o), .wreg_o(wreg_o), .valid_o(valid_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst_i = 0; stall_i = 0; flush_i = 0; valid_i = 0;
    rs_data_i = 0; rt_data_i = 0; imm_i = 0; rs_i = 0; rt_i = 0; rd_i = 0;
    alu_ctrl_i = 0; alu_src_i = 0; reg_dst_i = 0; reg_write_i = 0;
    mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0;
    exmem_reg_write_i = 0; exmem_wreg_i = 0; exmem_result_i = 0;
    memwb_reg_write_i = 0; memwb_wreg_i = 0; memwb_wdata_i = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  ctrl;
    logic        alu_src, reg_dst, reg_write;
    logic        ex_we;
    logic [4:0]  ex_wreg;
    logic [31:0] ex_res;
    logic        wb_we;
    logic [4:0]  wb_wreg;
    logic [31:0] wb_data;
    logic [31:0] e_src1, e_src2, e_store;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_wreg;
    logic        e_valid, e_rw;
  } vec_t;

  vec_t vecs[7];

  // ---------------- behavioural model ----------------
  // The model keeps the last accepted instruction (or nothing, for a bubble)
  // and derives operands from the hazard rules directly.
  typedef struct {
    logic        present;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  ctrl;
    logic        alu_src, reg_dst, rw, mr, mw, m2r;
  } instr_t;

  instr_t held;

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regval);
    if (idx == 0) return regval;
    if (exmem_reg_write_i && exmem_wreg_i == idx) return exmem_result_i;
    if (memwb_reg_write_i && memwb_wreg_i == idx) return memwb_wdata_i;
    return regval;
  endfunction

  task automatic model_edge();
    if (rst_i || flush_i) held.present = 0;
    else if (!stall_i) begin
      held.present = valid_i;
      held.rs_data = rs_data_i; held.rt_data = rt_data_i; held.imm = imm_i;
      held.rs = rs_i; held.rt = rt_i; held.rd = rd_i; held.ctrl = alu_ctrl_i;
      held.alu_src = alu_src_i; held.reg_dst = reg_dst_i; held.rw = reg_write_i;
      held.mr = mem_read_i; held.mw = mem_write_i; held.m2r = mem_to_reg_i;
    end
  endtask

  task automatic model_check();
    logic [31:0] a, b;
    if (!held.present) begin
      chk("rnd_ctl", {27'd0, valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o}, 32'd0);
      chk("rnd_aluctrl", {28'd0, ctrl_o}, 32'd0);
    end else begin
      a = operand(held.rs, held.rs_data);
      b = operand(held.rt, held.rt_data);
      chk("rnd_ctl", {27'd0, valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o},
          {27'd0, 1'b1, held.rw, held.mr, held.mw, held.m2r});
      chk("rnd_aluctrl", {28'd0, ctrl_o}, {28'd0, held.ctrl});
      chk("rnd_wreg", {27'd0, wreg_o}, {27'd0, (held.reg_dst ? held.rd : held.rt)});
      chk("rnd_src1", src1_o, a);
      chk("rnd_src2", src2_o, held.alu_src ? held.imm : b);
      chk("rnd_store", store_data_o, b);
    end
  endtask

  initial begin
    clear_inputs();

    //                   valid rs_data       rt_data       imm           rs rt rd ctrl alu_src reg_dst rw ex_we ex_wreg ex_res         wb_we wb_wreg wb_data     e_src1        e_src2        e_store       e_ctrl e_wreg e_valid e_rw
    vecs[0] = '{1, 32'd5,        32'd7,        32'd0,        1, 2, 9, 4'd2,  0, 1, 1, 0, 0, 32'd0,        0, 0, 32'd0,   32'd5,        32'd7,        32'd7,        4'd2,  9,  1, 1};
    vecs[1] = '{1, 32'd1,        32'd2,        32'd0,        3, 2, 0, 4'd6,  0, 0, 1, 1, 3, 32'h100,      1, 3, 32'h200, 32'h100,      32'd2,        32'd2,        4'd6,  2,  1, 1};
    vecs[2] = '{1, 32'h33,       32'd0,        32'd0,        1, 0, 0, 4'd7,  0, 0, 0, 1, 0, 32'hDEAD,     0, 0, 32'd0,   32'h33,       32'd0,        32'd0,        4'd7,  0,  1, 0};
    vecs[3] = '{1, 32'hA,        32'h99,       32'hFFFFFFFC, 5, 4, 0, 4'd2,  1, 0, 1, 0, 0, 32'd0,        1, 4, 32'h11,  32'hA,        32'hFFFFFFFC, 32'h11,       4'd2,  4,  1, 1};
    vecs[4] = '{1, 32'd1,        32'd2,        32'd0,        6, 7, 10, 4'd15, 0, 1, 1, 1, 7, 32'h55,      1, 6, 32'h77,  32'h77,       32'h55,       32'h55,       4'd15, 10, 1, 1};
    vecs[5] = '{1, 32'h1234,     32'h5678,     32'd0,        8, 8, 1, 4'd12, 0, 0, 0, 0, 8, 32'hBAD,      0, 8, 32'hBAD, 32'h1234,     32'h5678,     32'h5678,     4'd12, 8,  1, 0};
    vecs[6] = '{0, 32'h9,        32'h9,        32'h9,        3, 3, 3, 4'd2,  1, 1, 1, 0, 0, 32'd0,        0, 0, 32'd0,   32'd0,        32'd0,        32'd0,        4'd0,  0,  0, 0};

    // Reset held for two edges with a valid ADD on the inputs.
    rst_i = 1; valid_i = 1; alu_ctrl_i = ALU_ADD; reg_write_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_ctrl", {28'd0, ctrl_o}, 32'd0);
      chk("rst_rw", {31'd0, reg_write_o}, 32'd0);
    end
    clear_inputs();

    foreach (vecs[i]) begin
      valid_i = vecs[i].valid; rs_data_i = vecs[i].rs_data; rt_data_i = vecs[i].rt_data;
      imm_i = vecs[i].imm; rs_i = vecs[i].rs; rt_i = vecs[i].rt; rd_i = vecs[i].rd;
      alu_ctrl_i = vecs[i].ctrl; alu_src_i = vecs[i].alu_src; reg_dst_i = vecs[i].reg_dst;
      reg_write_i = vecs[i].reg_write;
      exmem_reg_write_i = vecs[i].ex_we; exmem_wreg_i = vecs[i].ex_wreg; exmem_result_i = vecs[i].ex_res;
      memwb_reg_write_i = vecs[i].wb_we; memwb_wreg_i = vecs[i].wb_wreg; memwb_wdata_i = vecs[i].wb_data;
      tick();
      chk($sformatf("v%0d_src1", i), src1_o, vecs[i].e_src1);
      chk($sformatf("v%0d_src2", i), src2_o, vecs[i].e_src2);
      chk($sformatf("v%0d_store", i), store_data_o, vecs[i].e_store);
      chk($sformatf("v%0d_ctrl", i), {28'd0, ctrl_o}, {28'd0, vecs[i].e_ctrl});
      chk($sformatf("v%0d_wreg", i), {27'd0, wreg_o}, {27'd0, vecs[i].e_wreg});
      chk($sformatf("v%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_rw", i), {31'd0, reg_write_o}, {31'd0, vecs[i].e_rw});
    end
    clear_inputs();

    // Stall holds an ADD; forwarding still tracks live EX/MEM inputs.
    valid_i = 1; rs_i = 1; rt_i = 2; rs_data_i = 32'h10; rt_data_i = 32'h20;
    alu_ctrl_i = ALU_ADD; reg_write_i = 1; mem_write_i = 1;
    tick();
    valid_i = 1; rs_i = 4; rt_i = 5; rs_data_i = 32'hEE; rt_data_i = 32'hFF;
    alu_ctrl_i = ALU_SUB; reg_write_i = 0; mem_write_i = 0; stall_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_src1", src1_o, 32'h10);
      chk("stall_src2", src2_o, 32'h20);
      chk("stall_ctrl", {28'd0, ctrl_o}, {28'd0, ALU_ADD});
      chk("stall_valid", {31'd0, valid_o}, 32'd1);
    end
    exmem_reg_write_i = 1; exmem_wreg_i = 1; exmem_result_i = 32'hABC;
    #1;
    chk("stall_fwd_src1", src1_o, 32'hABC);
    exmem_reg_write_i = 0;
    // Flush wins over a simultaneous stall.
    flush_i = 1;
    tick();
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    chk("flush_ctrl", {28'd0, ctrl_o}, 32'd0);
    chk("flush_mw", {31'd0, mem_write_o}, 32'd0);
    clear_inputs();

    // Randomized traffic with small register indices to provoke hazards.
    held.present = 0;
    rst_i = 1;
    @(posedge clk); model_edge(); #1;
    for (int c = 0; c < 400; c++) begin
      rst_i   = ($urandom_range(0, 49) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      stall_i = ($urandom_range(0, 4) == 0);
      valid_i = ($urandom_range(0, 5) != 0);
      rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
      rs_i = 5'($urandom_range(0, 3)); rt_i = 5'($urandom_range(0, 3)); rd_i = 5'($urandom);
      alu_ctrl_i = 4'($urandom); alu_src_i = 1'($urandom); reg_dst_i = 1'($urandom);
      reg_write_i = 1'($urandom); mem_read_i = 1'($urandom);
      mem_write_i = 1'($urandom); mem_to_reg_i = 1'($urandom);
      @(posedge clk);
      model_edge();
      #1;
      exmem_reg_write_i = 1'($urandom); exmem_wreg_i = 5'($urandom_range(0, 3));
      exmem_result_i = $urandom;
      memwb_reg_write_i = 1'($urandom); memwb_wreg_i = 5'($urandom_range(0, 3));
      memwb_wdata_i = $urandom;
      #1;
      model_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
